pdm_audio_tx: RTL and testbench

//  Audio playback path, complement of the PDM microphone capture path.
//  - Buffers unsigned offset-binary PCM samples in a small FIFO.
//  - Converts them to a 1-bit PDM stream with a first-order sigma-delta modulator.
//  - Drives the stream plus its bit clock to a speaker/amp filter pin.
//  - Derives the PDM bit rate from clk by an integer divider; holds each sample for OSR bits.

---
 rtl/pdm_audio_tx.sv | 122 ++++++++++++
 tb/tb_pdm_audio_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_audio_tx.sv
// PCM-to-PDM playback: FIFO-buffered offset-binary samples drive a first-order sigma-delta modulator.
// One sample popped per OSR bits, CLK_DIV clk per bit; s_ready = !full from registered level only.
module pdm_audio_tx #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 50,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [DATA_W-1:0]               s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic                            pdm_clk,
  output logic                            pdm_out,
  output logic                            sample_tick,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(OSR);

  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(OSR - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_vld;
  logic              pop_vld;

  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] cur_sample;
  logic [DATA_W:0]   sum;
  logic              bit_tick;
  logic              period_end;

  // Full is judged on the registered level, so a pop never frees a slot in its own cycle.
  assign fifo_full  = (fifo_level == LVL_FULL);
  assign fifo_empty = (fifo_level == '0);
  assign s_ready    = !fifo_full;
  assign push_vld   = s_valid && !fifo_full;
  assign pop_vld    = period_end && !fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_vld, pop_vld})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= s_data;
  end

  assign bit_tick   = enable && (div_cnt == DIV_LAST);
  assign period_end = bit_tick && (bit_cnt == BIT_LAST);
  assign div_nxt    = bit_tick ? '0 : div_cnt + DIV_W'(1);
  assign sum        = {1'b0, acc} + {1'b0, cur_sample};

  // pdm_clk tracks the count it is registered alongside, so its fall coincides with the new bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      acc         <= '0;
      cur_sample  <= MIDSCALE;
      pdm_clk     <= 1'b0;
      pdm_out     <= 1'b0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
      if (!enable) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        acc     <= '0;
        pdm_clk <= 1'b0;
        pdm_out <= 1'b0;
      end else begin
        div_cnt <= div_nxt;
        pdm_clk <= (div_nxt >= DIV_HALF);
        if (bit_tick) begin
          pdm_out <= sum[DATA_W];
          acc     <= sum[DATA_W-1:0];
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (period_end) begin
            if (!fifo_empty) begin
              cur_sample  <= mem[rd_ptr];
              sample_tick <= 1'b1;
            end else begin
              underrun <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_audio_tx.sv
// Bench for pdm_audio_tx: directed scenarios plus random traffic against a closed-form per-period model.
module tb_pdm_audio_tx;

  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 4;
  localparam int OSR     = 64;
  localparam int DEPTH   = 4;
  localparam int LVL_W   = $clog2(DEPTH + 1);
  localparam int K_TICK  = 2;   // {sample_tick, underrun}
  localparam int K_UNDER = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready, pdm_clk, pdm_out, sample_tick, underrun;
  logic [LVL_W-1:0]  fifo_level;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pdm_audio_tx #(
    .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .OSR(OSR), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .pdm_clk(pdm_clk), .pdm_out(pdm_out),
    .sample_tick(sample_tick), .underrun(underrun), .fifo_level(fifo_level)
  );

  // Reference model: sample queue, current sample, accumulator carried between periods.
  logic [DATA_W-1:0] q[$];
  int cur_m, acc_m;
  int bits, ones, since, hi, periods, inv_err;
  logic [OSR-1:0] vec, last_vec;
  int last_ones, last_kind;
  logic prev_clk, prev_out;

  logic [DATA_W-1:0] d4 [5] = '{8'h10, 8'h40, 8'h90, 8'hF0, 8'h30};
  int exp5 [5] = '{4, 16, 36, 60, 12};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inv(input string tag);
    chk(tag, inv_err, 0);
    inv_err = 0;
  endtask

  task automatic model_reset();
    q.delete();
    cur_m = 1 << (DATA_W - 1);
    acc_m = 0; bits = 0; ones = 0; since = 0; hi = 0;
    vec = '0; prev_clk = 1'b0; prev_out = 1'b0;
  endtask

  // Bit k of a period is the carry produced when the running total acc+k*s crosses a 2^DATA_W multiple.
  task automatic close_period(input int pre_size);
    logic [OSR-1:0] ev;
    int tot, ek;
    ev = '0;
    for (int k = 0; k < OSR; k++)
      ev[k] = (((acc_m + (k + 1) * cur_m) >> DATA_W) != ((acc_m + k * cur_m) >> DATA_W));
    tot = acc_m + OSR * cur_m;
    chk("period_bits", vec, ev);
    chk("period_ones", ones, tot >> DATA_W);
    acc_m = tot % (1 << DATA_W);
    if (pre_size > 0) begin
      ek = K_TICK;
      cur_m = q.pop_front();
    end else begin
      ek = K_UNDER;
    end
    chk("period_pulse", {sample_tick, underrun}, ek);
    last_ones = ones; last_vec = vec; last_kind = {sample_tick, underrun};
    periods++;
    bits = 0; ones = 0; vec = '0;
  endtask

  task automatic tick();
    logic v_pre, en_pre, fell;
    logic [DATA_W-1:0] d_pre;
    int pre_size;
    v_pre = s_valid; d_pre = s_data; en_pre = enable;
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
      if (pdm_clk !== 1'b0 || pdm_out !== 1'b0 || sample_tick !== 1'b0 || underrun !== 1'b0 ||
          s_ready !== 1'b1 || fifo_level !== '0) inv_err++;
      return;
    end
    pre_size = q.size();
    if (!en_pre) begin
      acc_m = 0; bits = 0; ones = 0; since = 0; hi = 0; vec = '0;
      if (pdm_clk !== 1'b0 || pdm_out !== 1'b0 || sample_tick !== 1'b0 || underrun !== 1'b0) inv_err++;
    end else begin
      since++;
      fell = prev_clk && !pdm_clk;
      if (pdm_out !== prev_out && !fell) inv_err++;
      if (fell) begin
        if (since != CLK_DIV || hi != CLK_DIV / 2) inv_err++;
        since = 0; hi = 0;
        vec[bits] = pdm_out;
        if (pdm_out === 1'b1) ones++;
        bits++;
        if (bits == OSR) close_period(pre_size);
        else if (sample_tick !== 1'b0 || underrun !== 1'b0) inv_err++;
      end else begin
        if (pdm_clk === 1'b1) hi++;
        if (sample_tick !== 1'b0 || underrun !== 1'b0) inv_err++;
      end
    end
    if (v_pre && pre_size < DEPTH) q.push_back(d_pre);
    if (fifo_level !== LVL_W'(q.size()) || s_ready !== (q.size() < DEPTH)) inv_err++;
    prev_clk = pdm_clk; prev_out = pdm_out;
  endtask

  task automatic wait_period(input string tag);
    int p0, c;
    p0 = periods; c = 0;
    while (periods == p0 && c < OSR * CLK_DIV + 50) begin
      tick();
      c++;
    end
    chk(tag, periods - p0, 1);
  endtask

  initial begin
    int c, p0, off, rate;
    bit seen;
    periods = 0; inv_err = 0; last_ones = 0; last_kind = 0; last_vec = '0;
    model_reset();

    // Reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_pdm_clk", pdm_clk, 0);
    chk("rst_pdm_out", pdm_out, 0);
    chk("rst_sample_tick", sample_tick, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_fifo_level", fifo_level, 0);
    tick(); tick();
    reset = 1'b0; enable = 1'b1;

    // 1: empty FIFO, midscale first period, underrun at its end
    wait_period("t1_timeout");
    chk("t1_ones", last_ones, 32);
    chk("t1_pattern", last_vec, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("t1_kind", last_kind, K_UNDER);
    chk_inv("t1_invariants");

    // 2: push 0x00 mid-period
    repeat (50) tick();
    s_valid = 1'b1; s_data = 8'h00; tick(); s_valid = 1'b0;
    wait_period("t2_timeout");
    chk("t2_kind", last_kind, K_TICK);
    chk("t2_ones", last_ones, 32);

    // 3: 0xC0 then 0x80 queued during the zero period
    repeat (10) tick();
    s_valid = 1'b1; s_data = 8'hC0; tick();
    s_data = 8'h80; tick(); s_valid = 1'b0;
    wait_period("t3_timeout_a");
    chk("t2_zero_ones", last_ones, 0);
    chk("t3_kind_a", last_kind, K_TICK);
    wait_period("t3_timeout_b");
    chk("t3_ones_c0", last_ones, 48);
    wait_period("t3_timeout_c");
    chk("t3_ones_80", last_ones, 32);
    chk("t3_kind_c", last_kind, K_UNDER);
    chk_inv("t3_invariants");

    // 4: fill while idle; fifth sample held by the source
    enable = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = d4[i];
      tick();
      chk("t4_level", fifo_level, i + 1);
      chk("t4_ready", s_ready, (i < 3));
    end
    s_data = d4[4];
    repeat (3) tick();
    chk("t4_level_full", fifo_level, 4);
    chk("t4_ready_full", s_ready, 0);

    // 5: re-enable with the push still asserted at the first pop edge
    enable = 1'b1;
    c = 0; seen = 1'b0;
    while (!seen && c < OSR * CLK_DIV + 50) begin
      tick();
      c++;
      if (sample_tick === 1'b1) seen = 1'b1;
    end
    chk("t5_pop_seen", seen, 1);
    chk("t5_level_at_pop", fifo_level, 3);
    chk("t5_ready_after_pop", s_ready, 1);
    chk("t5_first_ones", last_ones, 32);
    tick();
    chk("t5_level_refill", fifo_level, 4);
    chk("t5_ready_refill", s_ready, 0);
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_period("t4_drain_timeout");
      chk("t4_order_ones", last_ones, exp5[i]);
      chk("t4_order_kind", last_kind, (i < 4) ? K_TICK : K_UNDER);
    end
    chk_inv("t5_invariants");

    // 6: asynchronous reset mid-period with samples buffered
    s_valid = 1'b1; s_data = 8'h55; tick();
    s_data = 8'hAA; tick(); s_valid = 1'b0;
    tick(); tick();
    chk("t6_level_before", fifo_level, 2);
    c = 0;
    while (pdm_clk !== 1'b1 && c < 2 * CLK_DIV) begin
      tick();
      c++;
    end
    chk("t6_clk_high_before", pdm_clk, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_pdm_clk", pdm_clk, 0);
    chk("t6_pdm_out", pdm_out, 0);
    chk("t6_s_ready", s_ready, 1);
    chk("t6_fifo_level", fifo_level, 0);
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    wait_period("t6_timeout");
    chk("t6_ones", last_ones, 32);
    chk("t6_pattern", last_vec, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("t6_kind", last_kind, K_UNDER);
    chk_inv("t6_invariants");

    // Random traffic: bursty pushes, occasional enable drops
    p0 = periods; off = 0;
    for (int i = 0; i < 6000; i++) begin
      rate = (i < 3000) ? 30 : 300;
      s_valid = ($urandom_range(rate - 1, 0) == 0);
      s_data = DATA_W'($urandom);
      if (off > 0) begin
        enable = 1'b0;
        off--;
      end else begin
        enable = 1'b1;
        if ($urandom_range(799, 0) == 0) off = int'($urandom_range(40, 3));
      end
      tick();
    end
    s_valid = 1'b0;
    chk("rand_periods", ((periods - p0) >= 10), 1);
    chk_inv("rand_invariants");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
